adder_2bit_bist: RTL and testbench
==================================

ADDER_2BIT_BIST -- requirements
Module: adder_2bit_bist

Interface
REQ-001 The block SHALL have one parameter: SETTLE_CYCLES, default 2, the number of cycles the block waits after driving a vector before it samples the adder outputs (legal range 1..15).
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset; the ports SHALL be named clk and rst_n.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 Start  input  1  single-cycle run request, sampled on rising clk.
REQ-006 A  output  2  operand A driven to the adder_2bit under test, registered.
REQ-007 B  output  2  operand B driven to the adder_2bit under test, registered.
REQ-008 Sum  input  2  sum returned by the adder under test.
REQ-009 Carry  input  1  carry returned by the adder under test.
REQ-010 Busy  output  1  high while a run is in progress.
REQ-011 Done  output  1  high from run completion until the next accepted Start or reset.
REQ-012 Pass  output  1  valid while Done is high; 1 when Fail_cnt is 0.
REQ-013 Fail_cnt  output  5  count of mismatching vectors in the current or last run (0..16).
REQ-014 First_fail_vec  output  4  {A,B} of the first mismatching vector; valid when First_fail_valid is high.
REQ-015 First_fail_valid  output  1  high once a mismatch has been recorded in the current or last run.

Function
REQ-016 The FSM SHALL have the states IDLE, SETTLE, CHECK and DONE.
REQ-017 In IDLE or DONE, a sampled Start SHALL clear Fail_cnt, First_fail_valid, First_fail_vec and Done, set the vector index and {A,B} to 4'b0000, load the settle counter with SETTLE_CYCLES, and enter SETTLE.
REQ-018 In SETTLE or CHECK, Start SHALL be ignored.
REQ-019 SETTLE SHALL last exactly SETTLE_CYCLES cycles, with {A,B} held stable, and then move to CHECK.
REQ-020 CHECK SHALL last one cycle and compare {Carry,Sum} against the 3-bit zero-extended sum A+B.
REQ-021 On a mismatch in CHECK, Fail_cnt SHALL increment by 1; if First_fail_valid is 0, First_fail_vec SHALL capture {A,B} and First_fail_valid SHALL be set.
REQ-022 From CHECK with index < 15, the index and {A,B} SHALL advance by 1, the settle counter SHALL reload, and the FSM SHALL return to SETTLE.
REQ-023 From CHECK with index == 15, the FSM SHALL enter DONE.
REQ-024 In DONE, Done SHALL be 1, Busy SHALL be 0, and Pass SHALL equal (Fail_cnt == 0).
REQ-025 {A,B} SHALL hold 4'b1111 in DONE until the next Start.
REQ-026 Busy SHALL be high exactly in SETTLE and CHECK.
REQ-027 Pass SHALL be 0 whenever Done is 0.
REQ-028 Run latency SHALL be 16*(SETTLE_CYCLES+1) cycles: Done SHALL rise at that many rising edges after the edge that samples Start.
REQ-029 Fail_cnt SHALL NOT wrap; its maximum value is 16.

Reset
REQ-030 While rst_n is low, the FSM SHALL be IDLE and A, B, the index and the settle counter SHALL be 0.
REQ-031 While rst_n is low, Busy, Done, Pass, First_fail_valid, Fail_cnt and First_fail_vec SHALL be 0.
REQ-032 Reset assertion mid-run SHALL abort the run immediately; no partial result is retained.
REQ-033 The first Start after reset release SHALL behave as in REQ-017.

Structure
REQ-034 The state encoding, NUM_VECTORS = 16 and the Fail_cnt width SHALL live in a shared package, adder_bist_pkg.
REQ-035 The block SHALL contain no sub-module.
REQ-036 adder_2bit SHALL be instantiated beside this block at the next level up, with named port connections.

Verification
REQ-037 Correct adder, SETTLE_CYCLES=2, Start pulse -> Busy high for 48 cycles, then Done=1, Pass=1, Fail_cnt=0, First_fail_valid=0.
REQ-038 Carry stuck at 0 -> Done=1, Pass=0, Fail_cnt=6, First_fail_vec=4'b0111.
REQ-039 Sum[0] stuck at 0 -> Fail_cnt=8, First_fail_vec=4'b0001.
REQ-040 Start pulsed again at cycle 20 of a run -> ignored; Done still at cycle 48 with unchanged results.
REQ-041 rst_n low at cycle 30 of a run, then Start -> all outputs 0 during reset; the new run completes normally after 48 cycles.
REQ-042 SETTLE_CYCLES=1 with Start in DONE -> results cleared on the next edge; Done returns after 32 cycles.

Source files
------------

// File: rtl/adder_bist_pkg.sv
// Shared definitions for the 2-bit adder built-in self test: FSM encoding,
// vector count and result counter width.
package adder_bist_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int NUM_VECTORS = 16;
    localparam int VEC_W       = $clog2(NUM_VECTORS);
    localparam int FAIL_CNT_W  = 5;

endpackage

// File: rtl/adder_2bit.sv
// Plain 2-bit adder; the unit exercised by adder_2bit_bist from the level above.
module adder_2bit (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [1:0] sum,
    output logic       carry
);

    assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/adder_2bit_bist.sv
// Exhaustive self test for a 2-bit adder: walks all 16 {A,B} operand pairs,
// waits SETTLE_CYCLES per vector, and counts/records mismatching results.
module adder_2bit_bist
    import adder_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  Start,
    output logic [1:0]            A,
    output logic [1:0]            B,
    input  logic [1:0]            Sum,
    input  logic                  Carry,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Pass,
    output logic [FAIL_CNT_W-1:0] Fail_cnt,
    output logic [3:0]            First_fail_vec,
    output logic                  First_fail_valid
);

    localparam logic [3:0]            SETTLE_LOAD = 4'(SETTLE_CYCLES);
    localparam logic [VEC_W-1:0]      LAST_IDX    = VEC_W'(NUM_VECTORS - 1);
    localparam logic [FAIL_CNT_W-1:0] FAIL_MAX    = FAIL_CNT_W'(NUM_VECTORS);

    state_t           state, state_nxt;
    logic [VEC_W-1:0] idx;
    logic [3:0]       settle_cnt;
    logic             mismatch;

    // The operand pair is the vector index itself, so {A,B} walks 0..15.
    assign {A, B}   = idx;
    assign mismatch = ({Carry, Sum} != ({1'b0, A} + {1'b0, B}));

    assign Busy = (state == SETTLE) || (state == CHECK);
    assign Done = (state == DONE);
    assign Pass = Done && (Fail_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (Start) state_nxt = SETTLE;
            SETTLE:     if (settle_cnt <= 4'd1) state_nxt = CHECK;
            CHECK:      state_nxt = (idx == LAST_IDX) ? DONE : SETTLE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx              <= '0;
            settle_cnt       <= '0;
            Fail_cnt         <= '0;
            First_fail_vec   <= '0;
            First_fail_valid <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        idx              <= '0;
                        settle_cnt       <= SETTLE_LOAD;
                        Fail_cnt         <= '0;
                        First_fail_vec   <= '0;
                        First_fail_valid <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (settle_cnt != 4'd0) settle_cnt <= settle_cnt - 4'd1;
                end
                CHECK: begin
                    if (mismatch) begin
                        if (Fail_cnt != FAIL_MAX) Fail_cnt <= Fail_cnt + FAIL_CNT_W'(1);
                        if (!First_fail_valid) begin
                            First_fail_vec   <= {A, B};
                            First_fail_valid <= 1'b1;
                        end
                    end
                    // On the last vector idx stays at 15 so {A,B} holds 4'b1111 in DONE.
                    if (idx != LAST_IDX) begin
                        idx        <= idx + VEC_W'(1);
                        settle_cnt <= SETTLE_LOAD;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_2bit_bist.sv
// Bench for adder_2bit_bist: two instances (SETTLE_CYCLES 2 and 1), each beside
// an adder_2bit with injectable stuck-at faults, checked against an arithmetic model.
module tb_adder_2bit_bist;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start2, start1;
    int         fault_mode;

    logic [1:0] a2, b2, sum2_raw, sum2, a1, b1, sum1_raw, sum1;
    logic       carry2_raw, carry2, carry1_raw, carry1;
    logic       busy2, done2, pass2, ffval2, busy1, done1, pass1, ffval1;
    logic [4:0] fc2, fc1;
    logic [3:0] ffv2, ffv1;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    adder_2bit u_add2 (.a(a2), .b(b2), .sum(sum2_raw), .carry(carry2_raw));
    adder_2bit u_add1 (.a(a1), .b(b1), .sum(sum1_raw), .carry(carry1_raw));

    assign sum2   = (fault_mode == 2) ? {sum2_raw[1], 1'b0} : sum2_raw;
    assign carry2 = (fault_mode == 1) ? 1'b0 : carry2_raw;
    assign sum1   = (fault_mode == 2) ? {sum1_raw[1], 1'b0} : sum1_raw;
    assign carry1 = (fault_mode == 1) ? 1'b0 : carry1_raw;

    adder_2bit_bist #(.SETTLE_CYCLES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .Start(start2), .A(a2), .B(b2),
        .Sum(sum2), .Carry(carry2), .Busy(busy2), .Done(done2), .Pass(pass2),
        .Fail_cnt(fc2), .First_fail_vec(ffv2), .First_fail_valid(ffval2)
    );

    adder_2bit_bist #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .Start(start1), .A(a1), .B(b1),
        .Sum(sum1), .Carry(carry1), .Busy(busy1), .Done(done1), .Pass(pass1),
        .Fail_cnt(fc1), .First_fail_vec(ffv1), .First_fail_valid(ffval1)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        else passes++;
    endtask

    // A vector is faulty when the (possibly stuck) adder result differs from a+b.
    function automatic bit is_faulty(input int v, input int mode);
        int good, got;
        good = (v >> 2) + (v & 3);
        got  = good;
        if (mode == 1) got = good & 3;
        if (mode == 2) got = good & 6;
        return got != good;
    endfunction

    // Expected outputs n edges after the edge that accepted Start.
    task automatic model_out(input bit active, input int n, input int s, input int mode,
                             output logic busy, output logic done, output logic pass,
                             output logic [3:0] ab, output logic [4:0] fc,
                             output logic [3:0] ffv, output logic ffval);
        int len, nchk, vec;
        busy = 0; done = 0; pass = 0; ab = 0; fc = 0; ffv = 0; ffval = 0;
        if (active) begin
            len  = 16 * (s + 1);
            nchk = (n >= len) ? 16 : n / (s + 1);
            for (int v = 0; v < nchk; v++) begin
                if (is_faulty(v, mode)) begin
                    fc = fc + 5'd1;
                    if (!ffval) begin ffv = 4'(v); ffval = 1; end
                end
            end
            vec  = (n >= len) ? 15 : n / (s + 1);
            ab   = 4'(vec);
            busy = (n < len);
            done = (n >= len);
            pass = done && (fc == 0);
        end
    endtask

    bit act2 = 0, act1 = 0;
    int n2 = 0, n1 = 0, mode2 = 0, mode1 = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act2 <= 0; n2 <= 0; act1 <= 0; n1 <= 0;
        end else begin
            if (start2 && !(act2 && n2 < 48)) begin
                act2 <= 1; n2 <= 0; mode2 <= fault_mode;
            end else if (act2 && n2 < 48) n2 <= n2 + 1;
            if (start1 && !(act1 && n1 < 32)) begin
                act1 <= 1; n1 <= 0; mode1 <= fault_mode;
            end else if (act1 && n1 < 32) n1 <= n1 + 1;
        end
    end

    always @(negedge clk) begin
        logic eb, ed, ep, efv;
        logic [3:0] eab, effv;
        logic [4:0] efc;
        model_out(act2, n2, 2, mode2, eb, ed, ep, eab, efc, effv, efv);
        chk("s2_busy", 8'(busy2), 8'(eb));
        chk("s2_done", 8'(done2), 8'(ed));
        chk("s2_pass", 8'(pass2), 8'(ep));
        chk("s2_ab", 8'({a2, b2}), 8'(eab));
        chk("s2_fail_cnt", 8'(fc2), 8'(efc));
        chk("s2_ff_vec", 8'(ffv2), 8'(effv));
        chk("s2_ff_valid", 8'(ffval2), 8'(efv));
        model_out(act1, n1, 1, mode1, eb, ed, ep, eab, efc, effv, efv);
        chk("s1_busy", 8'(busy1), 8'(eb));
        chk("s1_done", 8'(done1), 8'(ed));
        chk("s1_pass", 8'(pass1), 8'(ep));
        chk("s1_ab", 8'({a1, b1}), 8'(eab));
        chk("s1_fail_cnt", 8'(fc1), 8'(efc));
        chk("s1_ff_vec", 8'(ffv1), 8'(effv));
        chk("s1_ff_valid", 8'(ffval1), 8'(efv));
    end

    // Pulses Start on the selected instance, then waits (bounded) for Done.
    task automatic run(input bit sel_s1, input int pulse_at, input int exp_lat,
                       input string tag);
        int lat, bc;
        if (sel_s1) start1 = 1; else start2 = 1;
        @(negedge clk);
        start1 = 0; start2 = 0;
        chk({tag, "_cleared_done"}, 8'(sel_s1 ? done1 : done2), 8'd0);
        chk({tag, "_cleared_cnt"}, 8'(sel_s1 ? fc1 : fc2), 8'd0);
        chk({tag, "_cleared_ffv"}, 8'(sel_s1 ? ffval1 : ffval2), 8'd0);
        lat = 0;
        bc  = int'(sel_s1 ? busy1 : busy2);
        while (!(sel_s1 ? done1 : done2) && lat < 400) begin
            @(negedge clk);
            lat++;
            bc += int'(sel_s1 ? busy1 : busy2);
            if (lat == pulse_at) begin
                if (sel_s1) start1 = 1; else start2 = 1;
            end else begin
                start1 = 0; start2 = 0;
            end
        end
        start1 = 0; start2 = 0;
        chk({tag, "_latency"}, 8'(lat), 8'(exp_lat));
        chk({tag, "_busy_cycles"}, 8'(bc), 8'(exp_lat));
    endtask

    initial begin
        rst_n = 0; start2 = 0; start1 = 0; fault_mode = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 8'(busy2), 8'd0);
        chk("rst_done", 8'(done2), 8'd0);
        chk("rst_ab", 8'({a2, b2}), 8'd0);
        chk("rst_fail_cnt", 8'(fc2), 8'd0);
        rst_n = 1;
        @(negedge clk);

        run(0, -1, 48, "good");
        chk("good_pass", 8'(pass2), 8'd1);
        chk("good_fail_cnt", 8'(fc2), 8'd0);
        chk("good_ff_valid", 8'(ffval2), 8'd0);
        chk("good_ab_hold", 8'({a2, b2}), 8'd15);

        fault_mode = 1;
        run(0, -1, 48, "carry0");
        chk("carry0_pass", 8'(pass2), 8'd0);
        chk("carry0_fail_cnt", 8'(fc2), 8'd6);
        chk("carry0_ff_vec", 8'(ffv2), 8'b0111);

        fault_mode = 2;
        run(0, -1, 48, "sum0");
        chk("sum0_fail_cnt", 8'(fc2), 8'd8);
        chk("sum0_ff_vec", 8'(ffv2), 8'b0001);

        fault_mode = 0;
        run(0, 19, 48, "restart_ignored");
        chk("restart_pass", 8'(pass2), 8'd1);

        fault_mode = 1;
        start2 = 1;
        @(negedge clk);
        start2 = 0;
        repeat (29) @(negedge clk);
        chk("midrun_partial_cnt", 8'(fc2), 8'd1);
        #2 rst_n = 0;
        #1;
        chk("async_busy", 8'(busy2), 8'd0);
        chk("async_fail_cnt", 8'(fc2), 8'd0);
        chk("async_ff_valid", 8'(ffval2), 8'd0);
        repeat (3) @(negedge clk);
        rst_n = 1;
        fault_mode = 0;
        @(negedge clk);
        run(0, -1, 48, "after_reset");
        chk("after_reset_pass", 8'(pass2), 8'd1);

        fault_mode = 2;
        run(1, -1, 32, "s1_sum0");
        chk("s1_sum0_fail_cnt", 8'(fc1), 8'd8);
        fault_mode = 0;
        run(1, -1, 32, "s1_rerun");
        chk("s1_rerun_pass", 8'(pass1), 8'd1);

        @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
